// File: rtl/alu_req_arbiter_pkg.sv
// Shared types, widths and ALU function codes for the ALU request arbiter.
package alu_req_arbiter_pkg;

  localparam int DATA_WIDTH_DEF     = 8;
  localparam int ALU_FUNC_WIDTH_DEF = 4;
  localparam int ALU_OUT_WIDTH_DEF  = 16;
  localparam int TIMEOUT_CYC_DEF    = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ISSUE = 2'b01,
    ST_WAIT  = 2'b10,
    ST_RESP  = 2'b11
  } arb_state_t;

  // Function codes understood by the shared ALU; only DIV is special-cased here.
  localparam logic [3:0] FUNC_ADD    = 4'b0000;
  localparam logic [3:0] FUNC_SUB    = 4'b0001;
  localparam logic [3:0] FUNC_MUL    = 4'b0010;
  localparam logic [3:0] FUNC_DIV    = 4'b0011;
  localparam logic [3:0] FUNC_AND    = 4'b0100;
  localparam logic [3:0] FUNC_OR     = 4'b0101;
  localparam logic [3:0] FUNC_XOR    = 4'b0110;
  localparam logic [3:0] FUNC_NOT    = 4'b0111;
  localparam logic [3:0] FUNC_CMP_EQ = 4'b1000;
  localparam logic [3:0] FUNC_CMP_GT = 4'b1001;
  localparam logic [3:0] FUNC_CMP_LT = 4'b1010;
  localparam logic [3:0] FUNC_INC    = 4'b1011;
  localparam logic [3:0] FUNC_DEC    = 4'b1100;
  localparam logic [3:0] FUNC_SHR    = 4'b1101;
  localparam logic [3:0] FUNC_SHL    = 4'b1110;

endpackage

// File: rtl/alu_req_arbiter_if.sv
// Request, ALU and response signals of the arbiter; slave is the arbiter's view.
interface alu_req_arbiter_if
  import alu_req_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH     = DATA_WIDTH_DEF,
  parameter int ALU_FUNC_WIDTH = ALU_FUNC_WIDTH_DEF,
  parameter int ALU_OUT_WIDTH  = ALU_OUT_WIDTH_DEF
);

  logic [1:0]                req;
  logic [DATA_WIDTH-1:0]     req_a0;
  logic [DATA_WIDTH-1:0]     req_b0;
  logic [ALU_FUNC_WIDTH-1:0] req_func0;
  logic [DATA_WIDTH-1:0]     req_a1;
  logic [DATA_WIDTH-1:0]     req_b1;
  logic [ALU_FUNC_WIDTH-1:0] req_func1;
  logic [1:0]                req_ack;

  logic [DATA_WIDTH-1:0]     alu_a;
  logic [DATA_WIDTH-1:0]     alu_b;
  logic [ALU_FUNC_WIDTH-1:0] alu_func;
  logic                      alu_en;
  logic [ALU_OUT_WIDTH-1:0]  alu_out;
  logic                      alu_out_valid;

  logic [1:0]                rsp_valid;
  logic [1:0]                rsp_ready;
  logic [ALU_OUT_WIDTH-1:0]  rsp_data;
  logic                      rsp_err;
  logic                      busy;

  modport master (
    output req, req_a0, req_b0, req_func0, req_a1, req_b1, req_func1,
    input  req_ack,
    input  alu_a, alu_b, alu_func, alu_en,
    output alu_out, alu_out_valid,
    input  rsp_valid, rsp_data, rsp_err, busy,
    output rsp_ready
  );

  modport slave (
    input  req, req_a0, req_b0, req_func0, req_a1, req_b1, req_func1,
    output req_ack,
    output alu_a, alu_b, alu_func, alu_en,
    input  alu_out, alu_out_valid,
    output rsp_valid, rsp_data, rsp_err, busy,
    input  rsp_ready
  );

endinterface

// File: rtl/alu_req_arbiter_rr_arb2.sv
// Combinational two-way round-robin pick; rr_ptr only matters when both request.
module alu_req_arbiter_rr_arb2 (
  input  logic [1:0] req,
  input  logic       rr_ptr,
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = rr_ptr ? 2'b10 : 2'b01;
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/alu_req_arbiter.sv
// Time-shares one registered ALU between two requesters (round robin) and
// returns each result, or a divide-by-zero/timeout error, over valid/ready.
module alu_req_arbiter
  import alu_req_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH     = DATA_WIDTH_DEF,
  parameter int ALU_FUNC_WIDTH = ALU_FUNC_WIDTH_DEF,
  parameter int ALU_OUT_WIDTH  = ALU_OUT_WIDTH_DEF,
  parameter int TIMEOUT_CYC    = TIMEOUT_CYC_DEF
) (
  input logic              CLK,
  input logic              RST,
  alu_req_arbiter_if.slave bus
);

  localparam int CNT_WIDTH = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_WIDTH-1:0]      CNT_LAST = CNT_WIDTH'(TIMEOUT_CYC - 1);
  localparam logic [ALU_FUNC_WIDTH-1:0] DIV_CODE = ALU_FUNC_WIDTH'(FUNC_DIV);

  arb_state_t                state;
  arb_state_t                state_nxt;
  logic                      rr_ptr;
  logic                      op_id;
  logic [1:0]                grant;
  logic [1:0]                req_ack;
  logic [1:0]                rsp_valid;
  logic [DATA_WIDTH-1:0]     op_a;
  logic [DATA_WIDTH-1:0]     op_b;
  logic [ALU_FUNC_WIDTH-1:0] op_func;
  logic [CNT_WIDTH-1:0]      tmo_cnt;
  logic [ALU_OUT_WIDTH-1:0]  rsp_data;
  logic                      rsp_err;
  logic                      alu_en;
  logic                      div_zero;
  logic                      tmo_hit;

  alu_req_arbiter_rr_arb2 u_rr_arb2 (
    .req    (bus.req),
    .rr_ptr (rr_ptr),
    .grant  (grant)
  );

  assign div_zero = (op_func == DIV_CODE) && (op_b == '0);
  assign tmo_hit  = (tmo_cnt == CNT_LAST);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state <= ST_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    req_ack   = 2'b00;
    alu_en    = 1'b0;
    rsp_valid = 2'b00;
    case (state)
      ST_IDLE: begin
        if (grant != 2'b00) begin
          req_ack   = grant;
          state_nxt = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        alu_en    = !div_zero;
        state_nxt = div_zero ? ST_RESP : ST_WAIT;
      end
      ST_WAIT: begin
        if (bus.alu_out_valid || tmo_hit) state_nxt = ST_RESP;
      end
      ST_RESP: begin
        rsp_valid[op_id] = 1'b1;
        if (bus.rsp_ready[op_id]) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Operand latch drives the ALU directly, so its inputs hold from ISSUE
  // through WAIT; the response register is only written on the way to RESP.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      rr_ptr   <= 1'b0;
      op_id    <= 1'b0;
      op_a     <= '0;
      op_b     <= '0;
      op_func  <= '0;
      tmo_cnt  <= '0;
      rsp_data <= '0;
      rsp_err  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (grant != 2'b00) begin
            op_id   <= grant[1];
            rr_ptr  <= ~grant[1];
            op_a    <= grant[1] ? bus.req_a1    : bus.req_a0;
            op_b    <= grant[1] ? bus.req_b1    : bus.req_b0;
            op_func <= grant[1] ? bus.req_func1 : bus.req_func0;
          end
        end
        ST_ISSUE: begin
          tmo_cnt <= '0;
          if (div_zero) begin
            rsp_data <= '0;
            rsp_err  <= 1'b1;
          end
        end
        ST_WAIT: begin
          if (bus.alu_out_valid) begin
            rsp_data <= bus.alu_out;
            rsp_err  <= 1'b0;
          end else if (tmo_hit) begin
            rsp_data <= '0;
            rsp_err  <= 1'b1;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.req_ack   = req_ack;
  assign bus.alu_a     = op_a;
  assign bus.alu_b     = op_b;
  assign bus.alu_func  = op_func;
  assign bus.alu_en    = alu_en;
  assign bus.rsp_valid = rsp_valid;
  assign bus.rsp_data  = rsp_data;
  assign bus.rsp_err   = rsp_err;
  assign bus.busy      = (state != ST_IDLE);

endmodule
